// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_sweep_pkg;

   localparam int unsigned ROW_W = 4;
   localparam int unsigned TT_W  = 16;

   // Sweep sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SAMPLE = 3'd2,
      COMMIT = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Row r lands in bit (15-r) so the word reads like a Cello design name
   function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] r);
      return ROW_W'(TT_W - 1) - r;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_sync.sv
// Flop chain bringing the asynchronous netlist output into the clk domain.
module tt_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   generate
      if (STAGES == 1) begin : g_one
         // Single-stage capture
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= d_i;
         end
      end else begin : g_chain
         // Shift the input through the chain, oldest sample at the top
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= {sync_q[STAGES-2:0], d_i};
         end
      end
   endgenerate

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input rows into a 4-input netlist, majority-filters the
// synchronised output per row and assembles/compares the truth-table word.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int unsigned     SETTLE_CYCLES = 8,
   parameter int unsigned     NUM_SAMPLES   = 3,
   parameter int unsigned     SYNC_STAGES   = 2,
   parameter logic [TT_W-1:0] EXPECTED_TT   = 16'h0026
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [ROW_W-1:0] dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic [TT_W-1:0]  tt,
   output logic [TT_W-1:0]  unstable,
   output logic             match,
   output logic [TT_W-1:0]  mismatch
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned ONES_W  = 4;

   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LOAD = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [ONES_W-1:0] ONES_HALF   = ONES_W'(NUM_SAMPLES / 2);
   localparam logic [ONES_W-1:0] ONES_ALL    = ONES_W'(NUM_SAMPLES);
   localparam logic [ROW_W-1:0]  LAST_ROW    = {ROW_W{1'b1}};

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ONES_W-1:0]  ones_q, ones_d;
   logic [ROW_W-1:0]   dut_in_q, dut_in_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [TT_W-1:0]    tt_q, tt_d;
   logic [TT_W-1:0]    unstable_q, unstable_d;
   logic               match_q, match_d;
   logic [TT_W-1:0]    mismatch_q, mismatch_d;
   logic               sync_out;

   tt_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (dut_out),
      .q_o   (sync_out)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, counters and capture logic; abort overrides everything outside IDLE
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      ones_d     = ones_q;
      dut_in_d   = dut_in_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tt_d       = tt_q;
      unstable_d = unstable_q;
      match_d    = match_q;
      mismatch_d = mismatch_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = APPLY;
               row_d      = '0;
               dut_in_d   = '0;
               cnt_d      = SETTLE_LOAD;
               ones_d     = '0;
               busy_d     = 1'b1;
               tt_d       = '0;
               unstable_d = '0;
               match_d    = 1'b0;
               mismatch_d = '0;
            end
         end
         APPLY: begin
            if (cnt_q == '0) begin
               state_d = SAMPLE;
               cnt_d   = SAMPLE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SAMPLE: begin
            ones_d = ones_q + ONES_W'(sync_out);
            if (cnt_q == '0) state_d = COMMIT;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         COMMIT: begin
            tt_d[row_bit(row_q)]       = (ones_q > ONES_HALF);
            unstable_d[row_bit(row_q)] = (ones_q != '0) && (ones_q != ONES_ALL);
            ones_d                     = '0;
            if (row_q == LAST_ROW) begin
               state_d = DONE;
            end else begin
               state_d  = APPLY;
               row_d    = row_q + ROW_W'(1);
               dut_in_d = row_q + ROW_W'(1);
               cnt_d    = SETTLE_LOAD;
            end
         end
         DONE: begin
            state_d    = IDLE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            match_d    = (tt_q == EXPECTED_TT);
            mismatch_d = tt_q ^ EXPECTED_TT;
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         row_d      = '0;
         cnt_d      = '0;
         ones_d     = '0;
         dut_in_d   = '0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         tt_d       = '0;
         unstable_d = '0;
         match_d    = 1'b0;
         mismatch_d = '0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q      <= '0;
         cnt_q      <= '0;
         ones_q     <= '0;
         dut_in_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tt_q       <= '0;
         unstable_q <= '0;
         match_q    <= 1'b0;
         mismatch_q <= '0;
      end else begin
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         dut_in_q   <= dut_in_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tt_q       <= tt_d;
         unstable_q <= unstable_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign dut_in   = dut_in_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tt       = tt_q;
   assign unstable = unstable_q;
   assign match    = match_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus queues the expected sweep result, a monitor
// checks it whenever done pulses.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [3:0]  dut_in;
   logic        dut_out;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic [15:0] unstable;
   logic        match;
   logic [15:0] mismatch;

   bit alt15  = 1'b0;
   bit glitch = 1'b0;

   always #5 clk = ~clk;

   // Reference netlist: out = in1 & (in3 | (in2 & in4)) & ~(in3 & in4)
   function automatic logic model(input logic [3:0] r, input bit alt);
      logic in1, in2, in3, in4, o;
      in1 = r[3]; in2 = r[2]; in3 = r[1]; in4 = r[0];
      o = in1 & (in3 | (in2 & in4)) & ~(in3 & in4);
      if (alt && (r == 4'd15)) o = 1'b1;
      return o;
   endfunction

   assign dut_out = model(dut_in, alt15) & ~glitch;

   truth_table_sweeper #(
      .SETTLE_CYCLES (4),
      .NUM_SAMPLES   (3),
      .SYNC_STAGES   (2),
      .EXPECTED_TT   (16'h0026)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .dut_in   (dut_in),
      .dut_out  (dut_out),
      .busy     (busy),
      .done     (done),
      .tt       (tt),
      .unstable (unstable),
      .match    (match),
      .mismatch (mismatch)
   );

   typedef struct {
      logic [15:0] tt;
      logic [15:0] unst;
      logic        m;
      logic [15:0] mm;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: pop and compare on every done pulse
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("latency",      32'(cyc - start_cyc), 32'd129);
               check("busy_at_done", {31'd0, busy},        32'd0);
               check("tt",           {16'd0, tt},          {16'd0, e.tt});
               check("unstable",     {16'd0, unstable},    {16'd0, e.unst});
               check("match",        {31'd0, match},       {31'd0, e.m});
               check("mismatch",     {16'd0, mismatch},    {16'd0, e.mm});
            end
         end
      end
   end

   task automatic push_exp(input logic [15:0] t, input logic [15:0] u, input logic m, input logic [15:0] mm);
      exp_t e;
      e.tt = t; e.unst = u; e.m = m; e.mm = mm;
      exp_q.push_back(e);
   endtask

   // Start pulse; returns #1 after the accepting edge with start_cyc recorded
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sweep_timeout: got %0d pending results expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic watch_quiet(input int n, input string name);
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) busy_cnt++;
      end
      check(name, 32'(busy_cnt), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int offs[3];
      offs[0] = 10; offs[1] = 63; offs[2] = 120;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;

      // 1. reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_dut_in",   {28'd0, dut_in},   32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_done",     {31'd0, done},     32'd0);
      check("rst_tt",       {16'd0, tt},       32'd0);
      check("rst_unstable", {16'd0, unstable}, 32'd0);
      check("rst_match",    {31'd0, match},    32'd0);
      check("rst_mismatch", {16'd0, mismatch}, 32'd0);

      // 2. clean sweep
      push_exp(16'h0026, 16'h0000, 1'b1, 16'h0000);
      pulse_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wait_idle(200);

      // 3. one-sample glitch on row 10
      push_exp(16'h0026, 16'h0020, 1'b1, 16'h0000);
      pulse_start();
      repeat (82) @(posedge clk);
      #1;
      check("glitch_row", {28'd0, dut_in}, 32'd10);
      glitch = 1'b1;
      @(posedge clk);
      #1;
      glitch = 1'b0;
      wait_idle(200);

      // 4. altered netlist: row 15 = 1
      alt15 = 1'b1;
      push_exp(16'h0027, 16'h0000, 1'b0, 16'h0001);
      pulse_start();
      wait_idle(200);
      alt15 = 1'b0;

      // 5. abort while row 7 is sampling
      pulse_start();
      repeat (60) @(posedge clk);
      #1;
      check("abort_row", {28'd0, dut_in}, 32'd7);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy",     {31'd0, busy},     32'd0);
      check("abort_dut_in",   {28'd0, dut_in},   32'd0);
      check("abort_tt",       {16'd0, tt},       32'd0);
      check("abort_unstable", {16'd0, unstable}, 32'd0);
      watch_quiet(150, "abort_stays_idle");
      push_exp(16'h0026, 16'h0000, 1'b1, 16'h0000);
      pulse_start();
      wait_idle(200);

      // 6a. extra start pulses during a sweep are ignored
      push_exp(16'h0026, 16'h0000, 1'b1, 16'h0000);
      pulse_start();
      foreach (offs[i]) begin
         while ((cyc - start_cyc) < offs[i]) @(posedge clk);
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle(200);
      watch_quiet(20, "no_restart_after_done");

      // 6b. async reset at row 3
      pulse_start();
      repeat (26) @(posedge clk);
      #1;
      check("rst_row", {28'd0, dut_in}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dut_in", {28'd0, dut_in}, 32'd0);
      check("arst_busy",   {31'd0, busy},   32'd0);
      check("arst_tt",     {16'd0, tt},     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      watch_quiet(150, "no_resume_after_reset");
      check("post_reset_dut_in", {28'd0, dut_in}, 32'd0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
